// File: rtl/sigmf_bwd.sv
// Three-stage backward pass of the sigmoid: d = g * y * (1 - y), signed Q8.24, valid/ready on both sides.
// Optional input clamp of y into [0, 1.0] is enabled by defining SIGMF_BWD_CLAMP_EN.
module sigmf_bwd #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_g,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_last,
    output logic             out_sat
);
    localparam logic [31:0] ONE = 32'h0100_0000;

    // Q8.24 multiply: 64-bit signed product, floor shift by 24, clip to 32 bits. Result is {sat, value}.
    function automatic logic [32:0] mul_sat(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] prod;
        logic signed [63:0] sh;
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        sh   = prod >>> 24;
        if (sh[63:31] != {33{sh[63]}})
            mul_sat = {1'b1, (sh[63] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        else
            mul_sat = {1'b0, sh[31:0]};
    endfunction

    logic        s1_valid_q, s2_valid_q, s3_valid_q;
    logic [31:0] s1_y_q, s1_omy_q, s1_g_q;
    logic        s1_last_q;
    logic [31:0] s2_p_q, s2_g_q;
    logic        s2_last_q, s2_sat_q;
    logic [31:0] s3_d_q;
    logic        s3_last_q, s3_sat_q;

    logic        stall;
    logic        accept;
    logic [31:0] y_c;
    logic [31:0] omy_d;
    logic [32:0] p_res;
    logic [32:0] d_res;

    assign stall    = s3_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        y_c = in_y;
`ifdef SIGMF_BWD_CLAMP_EN
        if (in_y[31])
            y_c = 32'h0;
        else if (in_y > ONE)
            y_c = ONE;
`endif
        omy_d = ONE - y_c;
    end

    assign p_res = mul_sat(s1_y_q, s1_omy_q);
    assign d_res = mul_sat(s2_g_q, s2_p_q);

    // Whole pipeline moves together; a stall freezes every stage so S3 holds its beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_omy_q   <= '0;
            s1_g_q     <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_g_q     <= '0;
            s2_last_q  <= 1'b0;
            s2_sat_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_d_q     <= '0;
            s3_last_q  <= 1'b0;
            s3_sat_q   <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            s1_y_q     <= y_c;
            s1_omy_q   <= omy_d;
            s1_g_q     <= in_g;
            s1_last_q  <= in_last;
            s2_valid_q <= s1_valid_q;
            s2_p_q     <= p_res[31:0];
            s2_g_q     <= s1_g_q;
            s2_last_q  <= s1_last_q;
            s2_sat_q   <= p_res[32];
            s3_valid_q <= s2_valid_q;
            s3_d_q     <= d_res[31:0];
            s3_last_q  <= s2_last_q;
            s3_sat_q   <= s2_sat_q | d_res[32];
        end
    end

    assign out_valid = s3_valid_q;
    assign out_d     = s3_d_q;
    assign out_last  = s3_last_q;
    assign out_sat   = s3_sat_q;
endmodule
